// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid and synchronous flush.
// Optional per-stage parity with a registered output check when DFF_PIPE_PARITY_EN is defined.
module dff_pipe #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         async_reset_n,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         d_valid,
    input  logic [WIDTH-1:0]             d,
`ifdef DFF_PIPE_PARITY_EN
    input  logic                         err_inject,
    output logic                         par_err,
`endif
    output logic                         q_valid,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] s_q [DEPTH];
    logic [WIDTH-1:0] s_d [DEPTH];
    logic [DEPTH-1:0] v_q, v_d;
    logic [OccW-1:0]  occ_q, occ_d;

    // Data only moves on advance; flush clears valids but leaves data untouched.
    always_comb begin
        s_d = s_q;
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else if (en) begin
            s_d[0] = d;
            v_d[0] = d_valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                s_d[i] = s_q[i-1];
                v_d[i] = v_q[i-1];
            end
        end
    end

    // Occupancy tracks the valid bits being loaded on this edge, so it never lags.
    always_comb begin
        occ_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OccW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s_q[i] <= RESET_VAL;
            end
            v_q   <= '0;
            occ_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                s_q[i] <= s_d[i];
            end
            v_q   <= v_d;
            occ_q <= occ_d;
        end
    end

    assign q         = s_q[DEPTH-1];
    assign q_valid   = v_q[DEPTH-1];
    assign occupancy = occ_q;

`ifdef DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] p_q, p_d;
    logic             par_err_q, par_err_d;

    always_comb begin
        p_d = p_q;
        if (!flush && en) begin
            p_d[0] = (^d) ^ err_inject;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                p_d[i] = p_q[i-1];
            end
        end
    end

    // Checked against the word currently held in the last stage, reported one cycle later.
    always_comb begin
        par_err_d = v_q[DEPTH-1] & ((^s_q[DEPTH-1]) ^ p_q[DEPTH-1]);
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            p_q       <= {DEPTH{^RESET_VAL}};
            par_err_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

    occ_bound_a: assert property (@(posedge clk) disable iff (!async_reset_n)
        occupancy <= OccW'(DEPTH));

    flush_empties_a: assert property (@(posedge clk) disable iff (!async_reset_n)
        flush |=> (occupancy == '0) && !q_valid);

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: directed vectors, valid words queued on issue, popped on output.
// Parity checks are compiled in when DFF_PIPE_PARITY_EN is defined.
module tb_dff_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  RVAL  = 8'hA5;

    logic       clk = 1'b0;
    logic       async_reset_n;
    logic       en, flush, d_valid;
    logic [7:0] d;
    logic       q_valid;
    logic [7:0] q;
    logic [2:0] occupancy;
`ifdef DFF_PIPE_PARITY_EN
    logic       err_inject;
    logic       par_err;
`endif

    int total = 0;
    int bad   = 0;
    int adv_cnt = 0;
    bit adv_flag = 1'b0;
    logic [7:0] exp_data [$];
    int         exp_stamp [$];

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .en            (en),
        .flush         (flush),
        .d_valid       (d_valid),
        .d             (d),
`ifdef DFF_PIPE_PARITY_EN
        .err_inject    (err_inject),
        .par_err       (par_err),
`endif
        .q_valid       (q_valid),
        .q             (q),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus side of the scoreboard: record every accepted valid word with its advance stamp.
    always @(posedge clk) begin
        adv_flag = 1'b0;
        if (async_reset_n === 1'b1) begin
            if (flush === 1'b1) begin
                exp_data.delete();
                exp_stamp.delete();
            end else if (en === 1'b1) begin
                adv_cnt++;
                adv_flag = 1'b1;
                if (d_valid === 1'b1) begin
                    exp_data.push_back(d);
                    exp_stamp.push_back(adv_cnt);
                end
            end
        end
    end

    // Monitor: a new output word exists only after an advancing edge.
    always @(negedge clk) begin
        if (adv_flag && q_valid === 1'b1) begin
            if (exp_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got q=%0h valid with nothing expected (t=%0t)",
                         q, $time);
            end else begin
                logic [7:0] ed;
                int         es;
                ed = exp_data.pop_front();
                es = exp_stamp.pop_front();
                chk("sb_data", 32'(q), 32'(ed));
                chk("sb_latency", 32'(adv_cnt - es + 1), 32'(DEPTH));
            end
        end
    end

    task automatic drive(input logic e, input logic f, input logic dv, input logic [7:0] dd);
        en      = e;
        flush   = f;
        d_valid = dv;
        d       = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic qv, input logic [2:0] occ);
        chk({tag, "_qv"}, 32'(q_valid), 32'(qv));
        chk({tag, "_occ"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin : main
        logic [2:0] occ_lat [9];
        logic       qv_lat  [9];
        logic [2:0] occ_st  [4];
        logic [7:0] q_st    [4];
        logic       qv_st   [4];
        occ_lat = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        qv_lat  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        occ_st  = '{3'd2, 3'd1, 3'd1, 3'd0};
        q_st    = '{8'h10, 8'h11, 8'h12, 8'h00};
        qv_st   = '{1'b1, 1'b0, 1'b1, 1'b0};

        async_reset_n = 1'b1;
        en = 1'b0; flush = 1'b0; d_valid = 1'b0; d = 8'h00;
`ifdef DFF_PIPE_PARITY_EN
        err_inject = 1'b0;
`endif
        // Asynchronous reset between edges, checked before any clock edge arrives.
        #12;
        async_reset_n = 1'b0;
        #1;
        chk("rst_q", 32'(q), 32'(RVAL));
        chk_out("rst", 1'b0, 3'd0);
`ifdef DFF_PIPE_PARITY_EN
        chk("rst_par_err", 32'(par_err), 32'd0);
`endif
        @(posedge clk);
        #1;
        async_reset_n = 1'b1;

        // Latency: five valid words then bubbles to drain.
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive(1'b1, 1'b0, 1'b1, 8'(i + 1));
            else       drive(1'b1, 1'b0, 1'b0, 8'h00);
            chk_out($sformatf("lat%0d", i), qv_lat[i], occ_lat[i]);
            if (i == 3) chk("lat_first_q", 32'(q), 32'h01);
        end

        // Stall and bubble.
        drive(1'b1, 1'b0, 1'b1, 8'h10);
        chk_out("stl_in0", 1'b0, 3'd1);
        drive(1'b1, 1'b0, 1'b0, 8'h11);
        chk_out("stl_in1", 1'b0, 3'd1);
        drive(1'b1, 1'b0, 1'b1, 8'h12);
        chk_out("stl_in2", 1'b0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'hEE);
            chk_out($sformatf("stl_hold%0d", i), 1'b0, 3'd2);
            chk($sformatf("stl_hold%0d_q", i), 32'(q), 32'h00);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            chk_out($sformatf("stl_out%0d", i), qv_st[i], occ_st[i]);
            chk($sformatf("stl_out%0d_q", i), 32'(q), 32'(q_st[i]));
        end

        // Flush beats enable; FF must never come out valid.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'(8'h20 + i));
        chk_out("fl_full", 1'b1, 3'd4);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        chk_out("fl_after", 1'b0, 3'd0);
        chk("fl_q_kept", 32'(q), 32'h20);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            chk_out($sformatf("fl_drain%0d", i), 1'b0, 3'd0);
        end

        // Reset mid-stream, 2 ns pulse between edges.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 8'(8'h30 + i));
        chk_out("mr_full", 1'b1, 3'd4);
        en = 1'b0; d_valid = 1'b0;
        #2;
        async_reset_n = 1'b0;
        exp_data.delete();
        exp_stamp.delete();
        #1;
        chk("mr_q", 32'(q), 32'(RVAL));
        chk_out("mr_rst", 1'b0, 3'd0);
        #1;
        async_reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'h3C);
        chk_out("mr_in", 1'b0, 3'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk_out("mr_out", 1'b1, 3'd1);
        chk("mr_out_q", 32'(q), 32'h3C);

`ifdef DFF_PIPE_PARITY_EN
        begin
            logic pe_exp [7];
            pe_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            for (int i = 0; i < 7; i++) begin
                err_inject = (i == 0);
                if (i < 2) drive(1'b1, 1'b0, 1'b1, 8'h07);
                else       drive(1'b1, 1'b0, 1'b0, 8'h00);
                chk($sformatf("par%0d", i), 32'(par_err), 32'(pe_exp[i]));
            end
            err_inject = 1'b0;
        end
`endif

        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
        chk("sb_drained", 32'(exp_data.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
